vga_stream_ctrl: RTL and testbench

- Parametrised successor to the fixed-timing VGA output path on the peripheral subsystem pins R_o/G_o/B_o/hSYNC_o/vSYNC_o.
- Generalised in colour depth, horizontal/vertical timing, pixel-clock divider and sync polarity.
- Accepts a valid/ready pixel stream into an internal FIFO. Adds a prime state, underflow detection and a start-of-frame pulse.
- Sits in the peripherals region, fed by a pixel-fetch engine, and drives the top-level VGA pads.

---
 rtl/vga_stream_pkg.sv | 15 +
 rtl/vga_stream_fifo.sv | 41 ++++
 rtl/vga_stream_ctrl.sv | 112 +++++++++++
 tb/tb_vga_stream_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/vga_stream_pkg.sv
// vga_stream_pkg: controller state type, default 640x480@60 timing and colour-bar helper
package vga_stream_pkg;
  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP = 16;
  localparam int DEF_H_SYNC = 96;
  localparam int DEF_H_BP = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP = 10;
  localparam int DEF_V_SYNC = 2;
  localparam int DEF_V_BP = 33;
  function automatic logic [2:0] bar_color(input int unsigned h, input int unsigned h_active);
    return 3'((h * 8) / h_active);
  endfunction
endpackage

// File: rtl/vga_stream_fifo.sv
// vga_stream_fifo: synchronous show-ahead FIFO with flush and occupancy count
module vga_stream_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic wr, rd;
  assign rd = pop && !empty;
  // a full FIFO still accepts a push when the same cycle pops
  assign wr = push && (!full || rd);
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk)
    if (wr) mem[wr_ptr] <= din;
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(wr);
      rd_ptr <= rd_ptr + AW'(rd);
      count <= count + CW'(wr) - CW'(rd);
    end
  end
endmodule

// File: rtl/vga_stream_ctrl.sv
// vga_stream_ctrl: streamed-pixel VGA timing generator with FIFO priming and underflow flag.
// Defining VGA_STREAM_TEST_PATTERN_EN adds test_pattern_i, showing 8 vertical colour bars.
module vga_stream_ctrl
  import vga_stream_pkg::*;
#(
  parameter int COLOR_W = 4,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP = DEF_H_FP,
  parameter int H_SYNC = DEF_H_SYNC,
  parameter int H_BP = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP = DEF_V_FP,
  parameter int V_SYNC = DEF_V_SYNC,
  parameter int V_BP = DEF_V_BP,
  parameter int PIX_DIV = 2,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int FIFO_DEPTH = 16,
  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int HW = $clog2(HT),
  localparam int VW = $clog2(VT)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable_i,
`ifdef VGA_STREAM_TEST_PATTERN_EN
  input  logic                   test_pattern_i,
`endif
  input  logic                   pix_valid_i,
  input  logic [3*COLOR_W-1:0]   pix_data_i,
  output logic                   pix_ready_o,
  input  logic                   underflow_clr_i,
  output logic                   underflow_o,
  output logic                   sof_o,
  output logic [HW-1:0]          h_cnt_o,
  output logic [VW-1:0]          v_cnt_o,
  output logic [COLOR_W-1:0]     R_o,
  output logic [COLOR_W-1:0]     G_o,
  output logic [COLOR_W-1:0]     B_o,
  output logic                   hSYNC_o,
  output logic                   vSYNC_o
);
  localparam int PW = 3 * COLOR_W;
  localparam int DW = PIX_DIV > 1 ? $clog2(PIX_DIV) : 1;
  state_t state;
  logic [DW-1:0] div;
  logic [31:0] hx, vx;
  logic tick, active, fifo_full, fifo_empty, pop, set_uf, pat;
  logic [PW-1:0] head, pat_rgb, rgb;
  logic [$clog2(FIFO_DEPTH):0] count;
  assign hx = 32'(h_cnt_o);
  assign vx = 32'(v_cnt_o);
  assign tick = state == RUN && enable_i && 32'(div) == PIX_DIV - 1;
  assign active = hx < H_ACTIVE && vx < V_ACTIVE;
  assign pop = tick && active && !pat && !fifo_empty;
  assign set_uf = tick && active && !pat && fifo_empty;
  assign pix_ready_o = !fifo_full && state != IDLE;
  assign {R_o, G_o, B_o} = rgb;
`ifdef VGA_STREAM_TEST_PATTERN_EN
  logic [2:0] bar;
  assign pat = test_pattern_i;
  assign bar = bar_color(hx, H_ACTIVE);
  assign pat_rgb = {{COLOR_W{bar[2]}}, {COLOR_W{bar[1]}}, {COLOR_W{bar[0]}}};
`else
  assign pat = 1'b0;
  assign pat_rgb = '0;
`endif
  vga_stream_fifo #(.WIDTH(PW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .flush(!enable_i || state == IDLE),
    .push(pix_valid_i && pix_ready_o),
    .pop(pop),
    .din(pix_data_i),
    .dout(head),
    .full(fifo_full),
    .empty(fifo_empty),
    .count(count)
  );
  // dropping enable abandons the frame immediately, same as reset except the sticky flag
  always_ff @(posedge clk) begin
    if (rst || !enable_i) begin
      state <= IDLE;
      div <= '0;
      h_cnt_o <= '0;
      v_cnt_o <= '0;
      rgb <= '0;
      hSYNC_o <= ~HSYNC_POL;
      vSYNC_o <= ~VSYNC_POL;
      sof_o <= 1'b0;
    end else begin
      sof_o <= tick && hx == 0 && vx == 0;
      if (state == IDLE) state <= PRIME;
      else if (state == PRIME) state <= 32'(count) >= FIFO_DEPTH / 2 ? RUN : PRIME;
      else begin
        div <= tick ? '0 : div + DW'(1);
        if (tick) begin
          rgb <= !active ? '0 : pat ? pat_rgb : fifo_empty ? '0 : head;
          hSYNC_o <= (hx >= H_ACTIVE + H_FP && hx < H_ACTIVE + H_FP + H_SYNC) ? HSYNC_POL : ~HSYNC_POL;
          vSYNC_o <= (vx >= V_ACTIVE + V_FP && vx < V_ACTIVE + V_FP + V_SYNC) ? VSYNC_POL : ~VSYNC_POL;
          h_cnt_o <= hx == HT - 1 ? '0 : h_cnt_o + HW'(1);
          if (hx == HT - 1) v_cnt_o <= vx == VT - 1 ? '0 : v_cnt_o + VW'(1);
        end
      end
    end
  end
  always_ff @(posedge clk)
    if (rst) underflow_o <= 1'b0;
    else if (set_uf) underflow_o <= 1'b1;
    else if (underflow_clr_i) underflow_o <= 1'b0;
endmodule

// File: tb/tb_vga_stream_ctrl.sv
// tb_vga_stream_ctrl: small-timing bench with a frame-arithmetic reference model and a pixel queue
module tb_vga_stream_ctrl;
  localparam int HA = 8, HF = 1, HS = 2, HB = 1;
  localparam int VA = 4, VF = 1, VS = 1, VB = 1;
  localparam int PD = 2, DEPTH = 16;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  logic clk = 0, rst = 1, en = 0, valid = 0, clr = 0, tp = 0;
  logic [11:0] data = '0;
  logic pix_ready, underflow, sof, hs, vs;
  logic [3:0] h_cnt, r_o, g_o, b_o;
  logic [2:0] v_cnt;
  int tests = 0, fails = 0, cyc = 0;
  int m_mode = 0, m_rc = 0;
  logic [11:0] q[$];
  logic [11:0] m_rgb = '0, nxt = 12'd14, first;
  logic m_hs = 1, m_vs = 1, m_sof = 0, m_uf = 0, m_push = 0;
  typedef struct {
    logic r, e, v, c;
    logic [11:0] d;
    logic [23:0] exp;
  } vec_t;
  vec_t tab[16];

  always #5 clk = ~clk;

  vga_stream_ctrl #(
    .COLOR_W(4), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .PIX_DIV(PD),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable_i(en),
`ifdef VGA_STREAM_TEST_PATTERN_EN
    .test_pattern_i(tp),
`endif
    .pix_valid_i(valid),
    .pix_data_i(data),
    .pix_ready_o(pix_ready),
    .underflow_clr_i(clr),
    .underflow_o(underflow),
    .sof_o(sof),
    .h_cnt_o(h_cnt),
    .v_cnt_o(v_cnt),
    .R_o(r_o),
    .G_o(g_o),
    .B_o(b_o),
    .hSYNC_o(hs),
    .vSYNC_o(vs)
  );

  function automatic logic [23:0] outs();
    return {r_o, g_o, b_o, hs, vs, sof, underflow, pix_ready, h_cnt, v_cnt};
  endfunction

  function automatic logic [23:0] pk(logic [11:0] rgb, logic s, logic rdy, logic [3:0] h);
    return {rgb, 1'b1, 1'b1, s, 1'b0, rdy, h, 3'd0};
  endfunction

  function automatic bit ntick();
    return m_mode == 2 && m_rc % PD == PD - 1;
  endfunction

  function automatic int npos();
    return (m_rc / PD) % (HT * VT);
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
    end
  endtask

  // one clock: drive inputs, advance the model on the edge, compare every output just after
  task automatic step(input logic r, input logic e, input logic vl, input logic c, input logic [11:0] d);
    logic rdy0, rdy1, sf;
    int p, h, v;
    logic [2:0] b;
    rst = r; en = e; valid = vl; clr = c; data = d;
    @(posedge clk);
    cyc++;
    rdy0 = m_mode != 0 && q.size() < DEPTH;
    m_push = 0; m_sof = 0; sf = 0;
    if (r || !e) begin
      m_mode = 0; q.delete(); m_rc = 0; m_rgb = '0; m_hs = 1; m_vs = 1;
      m_uf = r ? 1'b0 : c ? 1'b0 : m_uf;
    end else begin
      m_push = vl && rdy0;
      if (m_mode == 0) m_mode = 1;
      else if (m_mode == 1) begin
        if (q.size() >= DEPTH / 2) begin m_mode = 2; m_rc = 0; end
      end else begin
        if (m_rc % PD == PD - 1) begin
          p = (m_rc / PD) % (HT * VT); h = p % HT; v = p / HT;
          b = 3'(h * 8 / HA);
          if (!(h < HA && v < VA)) m_rgb = '0;
          else if (tp) m_rgb = {{4{b[2]}}, {4{b[1]}}, {4{b[0]}}};
          else if (q.size() > 0) m_rgb = q.pop_front();
          else begin m_rgb = '0; sf = 1; end
          m_hs = !(h >= HA + HF && h < HA + HF + HS);
          m_vs = !(v >= VA + VF && v < VA + VF + VS);
          m_sof = p == 0;
        end
        m_rc++;
      end
      if (m_push) q.push_back(d);
      m_uf = sf ? 1'b1 : c ? 1'b0 : m_uf;
    end
    #1;
    p = m_mode == 2 ? npos() : 0;
    rdy1 = m_mode != 0 && q.size() < DEPTH;
    check("model", 32'(outs()), 32'({m_rgb, m_hs, m_vs, m_sof, m_uf, rdy1, 4'(p % HT), 3'(p / HT)}));
  endtask

  task automatic stream1();
    step(0, 1, 1, 0, nxt);
    if (m_push) nxt++;
  endtask

  initial begin
    int k, t0, nh, nv, off;
    for (int i = 0; i < 16; i++) begin
      tab[i] = '{r: i == 0, e: i >= 2, v: i >= 3, c: 0, d: i >= 3 ? 12'(i - 2) : 12'h0,
                 exp: pk(12'h0, 0, i >= 2, 4'd0)};
    end
    tab[13].exp = pk(12'h001, 1, 1, 4'd1);
    tab[14].exp = pk(12'h001, 0, 1, 4'd1);
    tab[15].exp = pk(12'h002, 0, 1, 4'd2);
    for (int i = 0; i < 16; i++) begin
      step(tab[i].r, tab[i].e, tab[i].v, tab[i].c, tab[i].d);
      check($sformatf("table%0d", i), 32'(outs()), 32'(tab[i].exp));
    end
    // sof period over continuous streaming
    k = 0;
    while (!sof && k < 400) begin stream1(); k++; end
    check("sof_wait", 32'(sof), 1);
    t0 = cyc;
    stream1(); k = 1;
    while (!sof && k < 400) begin stream1(); k++; end
    check("sof_period", cyc - t0, 168);
    nh = 0; nv = 0;
    for (int i = 0; i < HT * VT * PD; i++) begin
      stream1();
      nh += int'(!hs); nv += int'(!vs);
    end
    check("hsync_cycles", nh, 28);
    check("vsync_cycles", nv, 24);
    // starve the stream until an active pixel finds the FIFO empty
    k = 0;
    while (!m_uf && k < 600) begin step(0, 1, 0, 0, 0); k++; end
    check("uf_set", 32'(underflow), 1);
    check("uf_black", 32'({r_o, g_o, b_o}), 0);
    k = 0;
    while (!(ntick() && npos() % HT < HA && npos() / HT < VA && q.size() == 0) && k < 400) begin
      step(0, 1, 0, 0, 0); k++;
    end
    step(0, 1, 0, 1, 0);
    check("uf_set_and_clr", 32'(underflow), 1);
    step(0, 1, 0, 1, 0);
    check("uf_clr_only", 32'(underflow), 0);
    // disable mid-frame at (3,2), then restart
    k = 0;
    while (!(m_mode == 2 && npos() == 2 * HT + 3) && k < 600) begin stream1(); k++; end
    check("at_3_2", 32'({h_cnt, v_cnt}), 32'({4'd3, 3'd2}));
    step(0, 0, 1, 0, nxt);
    check("disable_idle", 32'({r_o, g_o, b_o, hs, vs, pix_ready, h_cnt, v_cnt}), 32'({12'h0, 1'b1, 1'b1, 1'b0, 7'h0}));
    first = nxt;
    stream1(); k = 1;
    while (!sof && k < 400) begin stream1(); k++; end
    check("restart_first_pixel", 32'({r_o, g_o, b_o}), 32'(first));
    check("restart_pos", 32'({h_cnt, v_cnt}), 32'({4'd1, 3'd0}));
    for (int i = 0; i < 37; i++) stream1();
    step(1, 1, 1, 0, nxt);
    check("rst_run", 32'(outs()), 32'({12'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 3'h0}));
    // randomized traffic, dropouts, clears and resets
    off = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) off = $urandom_range(1, 5);
      step($urandom_range(0, 999) == 0, off == 0, $urandom_range(0, 9) < 8,
           $urandom_range(0, 29) == 0, 12'($urandom));
      if (off > 0) off--;
    end
`ifdef VGA_STREAM_TEST_PATTERN_EN
    k = 0;
    while (m_mode != 2 && k < 100) begin stream1(); k++; end
    tp = 1;
    step(0, 1, 0, 1, 0);
    k = 0;
    while (!(ntick() && npos() == 5) && k < 400) begin step(0, 1, 0, 0, 0); k++; end
    k = q.size();
    step(0, 1, 0, 0, 0);
    check("pattern_bar5", 32'({r_o, g_o, b_o}), 32'h0F0F);
    check("pattern_no_uf", 32'(underflow), 0);
    check("pattern_no_pop", q.size(), k);
    tp = 0;
    for (int i = 0; i < 200; i++) stream1();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
